// File: rtl/imem_stream_loader.sv
// imem_stream_loader
//   Assembles a little-endian 32-bit instruction image from a byte stream and
//   writes it into IMEM, holding the core in reset until the image is complete.
//   Stream format: count[7:0], count[15:8], then count*4 data bytes.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one trailing byte must equal the XOR of all header and data
//   bytes. On a match the load completes; otherwise it aborts.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   in_data       received byte
//   in_valid      in_data valid
//   in_ready      byte accepted this cycle when in_valid is also high
//   restart       pulse; leaves DONE/ERROR and re-arms the loader
//   imem_we       IMEM write strobe, one cycle per word
//   imem_waddr    IMEM byte address of the current word
//   imem_wdata    assembled instruction word
//   loader_done   image complete (sticky until restart)
//   core_rst_n    active-low core reset, mirrors loader_done
//   load_error    load aborted (sticky until restart)
//   words_loaded  words written in the current load
module imem_stream_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        restart,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        loader_done,
  output logic        core_rst_n,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StHdrLo, StHdrHi, StData, StWrite, StChk, StDone, StError
  } state_e;
  localparam state_e StFinal = StChk;
`else
  typedef enum logic [2:0] {
    StHdrLo, StHdrHi, StData, StWrite, StDone, StError
  } state_e;
  localparam state_e StFinal = StDone;
`endif

  state_e            r_state, w_state_nxt;
  logic [15:0]       r_count, w_count_nxt;
  logic [1:0]        r_idx, w_idx_nxt;
  logic [31:0]       r_word, w_word_nxt;
  logic [31:0]       r_waddr, w_waddr_nxt;
  logic [15:0]       r_words, w_words_nxt;
  logic [TmoW-1:0]   r_tmo, w_tmo_nxt;
  logic              w_ready_state;
  logic              w_accept;
  logic              w_rearm;
  logic [15:0]       w_hdr_count;

  assign w_ready_state = (r_state == StHdrLo) || (r_state == StHdrHi) ||
`ifdef LOADER_CHECKSUM_EN
                         (r_state == StChk) ||
`endif
                         (r_state == StData);
  // Gate with the raw reset so in_ready is low while reset is held.
  assign in_ready    = rst & w_ready_state;
  assign w_accept    = in_valid & in_ready;
  assign w_rearm     = restart && ((r_state == StDone) || (r_state == StError));
  assign w_hdr_count = {in_data, r_count[7:0]};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor, w_xor_nxt;

  always_comb begin
    w_xor_nxt = r_xor;
    if (w_rearm) begin
      w_xor_nxt = 8'h00;
    end else if (w_accept && (r_state != StChk)) begin
      w_xor_nxt = r_xor ^ in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xor <= 8'h00;
    end else begin
      r_xor <= w_xor_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_idx_nxt   = r_idx;
    w_word_nxt  = r_word;
    w_waddr_nxt = r_waddr;
    w_words_nxt = r_words;
    w_tmo_nxt   = r_tmo;

    unique case (r_state)
      StHdrLo: begin
        // No timeout here: the loader may wait forever for a first byte.
        if (w_accept) begin
          w_count_nxt[7:0] = in_data;
          w_tmo_nxt        = '0;
          w_state_nxt      = StHdrHi;
        end
      end

      StHdrHi: begin
        if (w_accept) begin
          w_count_nxt = w_hdr_count;
          w_tmo_nxt   = '0;
          if (w_hdr_count == 16'd0) begin
            w_state_nxt = StFinal;
          end else if (32'(w_hdr_count) > MAX_WORDS) begin
            w_state_nxt = StError;
          end else begin
            w_state_nxt = StData;
          end
        end else if (r_tmo == TmoLast) begin
          w_state_nxt = StError;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end

      StData: begin
        if (w_accept) begin
          unique case (r_idx)
            2'd0: w_word_nxt[7:0]   = in_data;
            2'd1: w_word_nxt[15:8]  = in_data;
            2'd2: w_word_nxt[23:16] = in_data;
            2'd3: w_word_nxt[31:24] = in_data;
            default: ;
          endcase
          w_idx_nxt = r_idx + 2'd1;
          w_tmo_nxt = '0;
          if (r_idx == 2'd3) begin
            w_state_nxt = StWrite;
          end
        end else if (r_tmo == TmoLast) begin
          w_state_nxt = StError;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end

      StWrite: begin
        // imem_we is high for exactly this cycle; advance for the next word.
        w_words_nxt = r_words + 16'd1;
        w_waddr_nxt = r_waddr + 32'd4;
        w_idx_nxt   = 2'd0;
        if (w_words_nxt == r_count) begin
          w_state_nxt = StFinal;
        end else begin
          w_state_nxt = StData;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (w_accept) begin
          w_tmo_nxt   = '0;
          w_state_nxt = (in_data == r_xor) ? StDone : StError;
        end else if (r_tmo == TmoLast) begin
          w_state_nxt = StError;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
`endif

      StDone, StError: begin
        if (w_rearm) begin
          w_state_nxt = StHdrLo;
          w_words_nxt = 16'd0;
          w_idx_nxt   = 2'd0;
          w_waddr_nxt = BASE_ADDR;
          w_tmo_nxt   = '0;
        end
      end

      default: w_state_nxt = StHdrLo;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StHdrLo;
      r_count <= 16'd0;
      r_idx   <= 2'd0;
      r_word  <= 32'd0;
      r_waddr <= BASE_ADDR;
      r_words <= 16'd0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_idx   <= w_idx_nxt;
      r_word  <= w_word_nxt;
      r_waddr <= w_waddr_nxt;
      r_words <= w_words_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  assign imem_we      = (r_state == StWrite);
  assign imem_waddr   = r_waddr;
  assign imem_wdata   = r_word;
  assign loader_done  = (r_state == StDone);
  assign core_rst_n   = loader_done;
  assign load_error   = (r_state == StError);
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader (small timeout so aborts are quick).
module tb_imem_stream_loader;

  localparam logic [31:0] Base = 32'h0000_0000;
  localparam int unsigned MaxW = 1024;
  localparam int unsigned Tmo  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        restart = 1'b0;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        loader_done;
  logic        core_rst_n;
  logic        load_error;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;
  logic [7:0] bx;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t         wlog[$];
  logic [31:0] img[$];

  typedef struct {
    logic [15:0] count;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_words;
    int          exp_writes;
  } vec_t;
  vec_t vt[7];

  imem_stream_loader #(
    .BASE_ADDR     (Base),
    .MAX_WORDS     (MaxW),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .restart     (restart),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .loader_done (loader_done),
    .core_rst_n  (core_rst_n),
    .load_error  (load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_t w;
      w.addr = imem_waddr;
      w.data = imem_wdata;
      wlog.push_back(w);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called one step after a clock edge; returns one step after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    bx = bx ^ b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input logic corrupt);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = corrupt ? ~bx : bx;
    send_byte(c, 0);
`endif
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    check("rs_done", 32'(loader_done), 32'd0);
    check("rs_err", 32'(load_error), 32'd0);
    check("rs_core", 32'(core_rst_n), 32'd0);
    check("rs_words", 32'(words_loaded), 32'd0);
    check("rs_waddr", imem_waddr, Base);
    check("rs_ready", 32'(in_ready), 32'd1);
  endtask

  // Sends a full image from img[] and compares with what the stream rules imply.
  task automatic run_load(input logic [15:0] count, input int gapmax, input logic corrupt);
    logic        chk_bad;
    logic        exp_err;
    logic [31:0] w;
    int          exp_wr;
    int          mism;
    wlog.delete();
    bx = 8'h00;
    send_byte(count[7:0], $urandom_range(0, gapmax));
    send_byte(count[15:8], $urandom_range(0, gapmax));
    chk_bad = 1'b0;
    if (32'(count) <= MaxW) begin
      for (int i = 0; i < int'(count); i++) begin
        w = img[i];
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, gapmax));
      end
      send_chk(corrupt);
`ifdef LOADER_CHECKSUM_EN
      chk_bad = corrupt;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    exp_wr  = (32'(count) <= MaxW) ? int'(count) : 0;
    exp_err = (32'(count) > MaxW) || chk_bad;
    check("ld_done", 32'(loader_done), 32'(!exp_err));
    check("ld_core", 32'(core_rst_n), 32'(!exp_err));
    check("ld_err", 32'(load_error), 32'(exp_err));
    check("ld_words", 32'(words_loaded), 32'(exp_wr));
    check("ld_we_idle", 32'(imem_we), 32'd0);
    check("ld_nwrites", 32'(wlog.size()), 32'(exp_wr));
    mism = 0;
    for (int i = 0; i < wlog.size() && i < exp_wr; i++) begin
      if (wlog[i].addr !== Base + 32'(4 * i) || wlog[i].data !== img[i]) mism++;
    end
    check("ld_write_mismatches", 32'(mism), 32'd0);
  endtask

  initial begin
    int k;
    vt[0] = '{16'd0,     1'b1, 1'b0, 16'd0,    0};
    vt[1] = '{16'd1,     1'b1, 1'b0, 16'd1,    1};
    vt[2] = '{16'd3,     1'b1, 1'b0, 16'd3,    3};
    vt[3] = '{16'd1024,  1'b1, 1'b0, 16'd1024, 1024};
    vt[4] = '{16'd1025,  1'b0, 1'b1, 16'd0,    0};
    vt[5] = '{16'h0401,  1'b0, 1'b1, 16'd0,    0};
    vt[6] = '{16'hFFFF,  1'b0, 1'b1, 16'd0,    0};

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_waddr", imem_waddr, Base);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_done", 32'(loader_done), 32'd0);
    check("rst_core", 32'(core_rst_n), 32'd0);
    check("rst_err", 32'(load_error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(in_ready), 32'd1);

    // Directed example stream with 3-cycle pauses inside word 1.
    wlog.delete();
    bx = 8'h00;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 3);
    send_byte(8'h00, 3);
    send_byte(8'h00, 3);
    send_byte(8'hB3, 0);
    send_byte(8'h00, 0);
    send_byte(8'h52, 0);
    send_byte(8'h00, 0);
    check("tp_we", 32'(imem_we), 32'd1);
    check("tp_addr1", imem_waddr, 32'h4);
    check("tp_data1", imem_wdata, 32'h005200B3);
    check("tp_done_early", 32'(loader_done), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    send_chk(1'b0);
`else
    @(posedge clk);
    #1;
`endif
    check("tp_done", 32'(loader_done), 32'd1);
    check("tp_core", 32'(core_rst_n), 32'd1);
    check("tp_we_off", 32'(imem_we), 32'd0);
    check("tp_words", 32'(words_loaded), 32'd2);
    check("tp_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() >= 1) begin
      check("tp_addr0", wlog[0].addr, 32'h0);
      check("tp_data0", wlog[0].data, 32'h00000013);
    end
    // Restart together with a valid byte: restart wins, byte is dropped.
    in_data  = 8'h05;
    in_valid = 1'b1;
    restart  = 1'b1;
    @(posedge clk);
    #1;
    restart  = 1'b0;
    in_valid = 1'b0;
    check("rv_done", 32'(loader_done), 32'd0);
    img.delete();
    img.push_back(32'hCAFE_F00D);
    run_load(16'd1, 0, 1'b0);
    do_restart();

    // Table of header counts, including the boundary at MAX_WORDS.
    img.delete();
    for (int i = 0; i < 1024; i++) img.push_back(32'(i) * 32'h9E37_79B9);
    for (int v = 0; v < 7; v++) begin
      run_load(vt[v].count, 0, 1'b0);
      check("tbl_done", 32'(loader_done), 32'(vt[v].exp_done));
      check("tbl_err", 32'(load_error), 32'(vt[v].exp_err));
      check("tbl_words", 32'(words_loaded), 32'(vt[v].exp_words));
      check("tbl_writes", 32'(wlog.size()), 32'(vt[v].exp_writes));
      do_restart();
    end

    // Timeout: stall mid-word, expect abort 16 cycles after the last accept.
    wlog.delete();
    bx = 8'h00;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    k = 0;
    while (!load_error && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("tmo_cycles", 32'(k), 32'd16);
    check("tmo_core", 32'(core_rst_n), 32'd0);
    check("tmo_no_we", 32'(wlog.size()), 32'd0);
    do_restart();
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'h1234_5678);
    run_load(16'd2, 2, 1'b0);
    do_restart();

    // Restart mid-load is ignored.
    wlog.delete();
    bx = 8'h00;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    send_chk(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("ign_done", 32'(loader_done), 32'd1);
    check("ign_words", 32'(words_loaded), 32'd1);
    check("ign_nwrites", 32'(wlog.size()), 32'd1);
    if (wlog.size() >= 1) check("ign_data", wlog[0].data, 32'hDDCC_BBAA);
    do_restart();

`ifdef LOADER_CHECKSUM_EN
    // Checksum accept and reject.
    bx = 8'h00;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    check("chk_good_done", 32'(loader_done), 32'd1);
    do_restart();
    bx = 8'h00;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    check("chk_bad_err", 32'(load_error), 32'd1);
    check("chk_bad_core", 32'(core_rst_n), 32'd0);
    do_restart();
`endif

    // Asynchronous reset in the middle of word 3 of a 4-word load.
    wlog.delete();
    bx = 8'h00;
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 9; i++) send_byte(8'(i + 1), 0);
    check("mid_words", 32'(words_loaded), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("ar_ready", 32'(in_ready), 32'd0);
    check("ar_we", 32'(imem_we), 32'd0);
    check("ar_waddr", imem_waddr, Base);
    check("ar_wdata", imem_wdata, 32'd0);
    check("ar_done", 32'(loader_done), 32'd0);
    check("ar_core", 32'(core_rst_n), 32'd0);
    check("ar_err", 32'(load_error), 32'd0);
    check("ar_words", 32'(words_loaded), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    img.delete();
    img.push_back(32'h0BAD_F00D);
    img.push_back(32'h7777_0001);
    run_load(16'd2, 1, 1'b0);
    do_restart();

    // Randomized loads checked against the stream rules.
    for (int r = 0; r < 24; r++) begin
      logic [15:0] cnt;
      logic        corrupt;
      img.delete();
      for (int i = 0; i < 6; i++) img.push_back($urandom);
      if ($urandom_range(0, 7) == 0) cnt = 16'($urandom_range(1025, 65535));
      else cnt = 16'($urandom_range(0, 6));
      corrupt = ($urandom_range(0, 3) == 0);
      run_load(cnt, 3, corrupt);
      do_restart();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
Upstream neighbour of the pipeline top. It receives a byte stream from the UART receive block over a valid/ready handshake and assembles little-endian 32-bit instruction words. It drives the IMEM write interface (imem_we/imem_waddr/imem_wdata) and the loader_done_in input of the pipeline top, and holds the core in reset until the program image is fully written.

Parameters:
BASE_ADDR, 32'h0000_0000, IMEM byte address of the first word
MAX_WORDS, 1024, largest accepted word count; a header above this is an error
TIMEOUT_CYCLES, 100000, idle cycles allowed between bytes mid-load before aborting; minimum 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
in_data  input  8  received byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts the byte this cycle
restart  input  1  single-cycle pulse: leave DONE/ERROR and re-arm
imem_we  output  1  IMEM write strobe, one cycle per word
imem_waddr  output  32  IMEM byte address
imem_wdata  output  32  assembled instruction word
loader_done  output  1  sticky; image complete (drives loader_done_in)
core_rst_n  output  1  active-low core reset; equals loader_done
load_error  output  1  sticky; load aborted
words_loaded  output  16  count of words written in the current load

Behaviour:
- Reset (rst=0, async): state=HDR_LO; in_ready=0 during reset, 1 after release; imem_we=0; imem_waddr=BASE_ADDR; imem_wdata=0; loader_done=0; core_rst_n=0; load_error=0; words_loaded=0; byte index=0; timeout counter=0.
- Accept = in_valid && in_ready. in_ready=1 only in HDR_LO, HDR_HI, DATA and CHK; it is 0 in WRITE, DONE and ERROR.
- HDR_LO: on accept, latch count[7:0] and go to HDR_HI.
- HDR_HI: on accept, form count = {byte, count[7:0]}.
  - count == 0 -> DONE (or CHK when the checksum option is enabled).
  - count > MAX_WORDS -> ERROR.
  - otherwise -> DATA.
- DATA: on accept, place the byte in lane idx (idx 0 = bits[7:0]) and increment idx.
  - When the 4th byte is accepted at cycle t, go to WRITE. imem_we=1 at t+1 with imem_wdata = the complete word and imem_waddr = BASE_ADDR + 4*words_loaded.
- WRITE (exactly one cycle): after the strobe, words_loaded increments and imem_waddr advances by 4.
  - If words_loaded == count, go to DONE (or CHK). Otherwise go to DATA with idx=0.
- DONE: loader_done=1 and core_rst_n=1; both are held. Bytes are not accepted.
- ERROR: load_error=1; core_rst_n stays 0; imem_we is never asserted.
- Timeout: the counter runs in HDR_HI, DATA and CHK and clears on every accept. Reaching TIMEOUT_CYCLES -> ERROR. The counter is idle in HDR_LO, so the loader can wait indefinitely before the first byte.
- restart: honoured only in DONE or ERROR. It returns the block to HDR_LO, clears loader_done, load_error, words_loaded and idx, sets imem_waddr=BASE_ADDR and deasserts core_rst_n. restart is ignored in all other states.
- Simultaneous restart and in_valid in DONE/ERROR: restart wins; the byte is not accepted because in_ready=0.
- imem_waddr wraps modulo 2^32; no overflow check is performed.
- Reset mid-load: the image is abandoned immediately. Words already written stay in IMEM; all outputs return to their reset values.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined: a running XOR covers every accepted header and data byte. After the last word (or after a zero count) the state is CHK, which accepts one more byte. If that byte equals the XOR -> DONE; otherwise -> ERROR. The XOR register is cleared on reset and on restart.
- Not defined: there is no CHK state and no XOR register. The state goes directly to DONE after the final WRITE, or after HDR_HI when count is 0.

Test Plan:
- Stream 02 00 | 13 00 00 00 | B3 00 52 00 (checksum off) -> imem_we pulses twice: addr 0x0 data 0x00000013, addr 0x4 data 0x005200B3. loader_done=1 and core_rst_n=1 one cycle after the second pulse; words_loaded=2.
- Hold in_valid low for 3 cycles between bytes of word 1 -> identical writes; no timeout with TIMEOUT_CYCLES=100000.
- Header 01 04 (0x0401 > 1024) -> ERROR on the cycle after accept; load_error=1; imem_we never asserted; core_rst_n=0.
- TIMEOUT_CYCLES=16: send 01 00 13 and then stop -> load_error=1 sixteen cycles after the last accept. restart pulse -> HDR_LO; a full reload then succeeds from addr 0x0.
- LOADER_CHECKSUM_EN: send 01 00 13 00 00 00 then 12 -> DONE. Send 01 00 13 00 00 00 then 13 -> ERROR.
- Assert rst during DATA after 2 words of a 4-word load -> all outputs return to reset values asynchronously. A fresh stream after release reloads from BASE_ADDR.
